wb_port_arbiter: RTL and testbench

// - Shares the physical register file's 2 write ports among NUM_REQ functional-unit writeback requesters.
// - Requesters are ALU0, ALU1, MUL and LSU.
// - Grants up to 2 requests per cycle with rotating priority.
// - Registers the winners and drives the register file write ports plus the CDB wakeup/completion broadcast.
// - Sits between FU result stages and reg_file / reservation stations / ROB.

---
 rtl/wb_port_arbiter_pkg.sv | 28 ++
 rtl/wb_port_arbiter_rr_pick2.sv | 45 ++++
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback-arbiter types: requester indices, port count and the
// writeback request payload layout.
package wb_port_arbiter_pkg;

  localparam int NUM_WB_PORTS = 2;

  localparam int WB_NUM_REQ_DEF = 4;
  localparam int WB_PREG_W_DEF  = 7;
  localparam int WB_DATA_W_DEF  = 32;
  localparam int WB_ROB_W_DEF   = 5;

  localparam int WB_REQ_ALU0 = 0;
  localparam int WB_REQ_ALU1 = 1;
  localparam int WB_REQ_MUL  = 2;
  localparam int WB_REQ_LSU  = 3;

  typedef struct packed {
    logic [WB_PREG_W_DEF-1:0] pd;
    logic [WB_ROB_W_DEF-1:0]  rob;
    logic [WB_DATA_W_DEF-1:0] data;
  } wb_req_t;

  // Increment a requester index with wrap-around at n.
  function automatic int wb_next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick2.sv
// Combinational two-winner picker: scans the valid vector upward from
// rr_ptr (modulo N) and reports the first and second valid requesters.
module wb_port_arbiter_rr_pick2 #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N-1:0]     gnt0_o,
  output logic [N-1:0]     gnt1_o,
  output logic             found0_o,
  output logic             found1_o,
  output logic [PTR_W-1:0] idx0_o,
  output logic [PTR_W-1:0] idx1_o
);

  logic [PTR_W:0] scan;

  always_comb begin
    gnt0_o   = '0;
    gnt1_o   = '0;
    found0_o = 1'b0;
    found1_o = 1'b0;
    idx0_o   = '0;
    idx1_o   = '0;
    scan     = '0;
    for (int k = 0; k < N; k++) begin
      // Extra bit keeps rr_ptr + k from overflowing before the wrap.
      scan = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(N)) scan = scan - (PTR_W+1)'(N);
      if (valid_i[scan[PTR_W-1:0]] && !found1_o) begin
        if (!found0_o) begin
          found0_o                   = 1'b1;
          gnt0_o[scan[PTR_W-1:0]]    = 1'b1;
          idx0_o                     = scan[PTR_W-1:0];
        end else begin
          found1_o                   = 1'b1;
          gnt1_o[scan[PTR_W-1:0]]    = 1'b1;
          idx1_o                     = scan[PTR_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: grants up to two FU results per cycle onto the register
// file write ports and the CDB, with rotating priority and a 1-cycle stage.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_NUM_REQ_DEF,
  parameter int PREG_W  = WB_PREG_W_DEF,
  parameter int DATA_W  = WB_DATA_W_DEF,
  parameter int ROB_W   = WB_ROB_W_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ-1:0][PREG_W-1:0]          req_pd,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]          req_data,
  input  logic [NUM_REQ-1:0][ROB_W-1:0]           req_rob,
  output logic [NUM_WB_PORTS-1:0]                 regf_we,
  output logic [NUM_WB_PORTS-1:0][PREG_W-1:0]     rd_s,
  output logic [NUM_WB_PORTS-1:0][DATA_W-1:0]     rd_v,
  output logic [NUM_WB_PORTS-1:0]                 cdb_valid,
  output logic [NUM_WB_PORTS-1:0][PREG_W-1:0]     cdb_pd,
  output logic [NUM_WB_PORTS-1:0][ROB_W-1:0]      cdb_rob
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_WB_PORTS-1:0]              valid_q, valid_d;
  logic [NUM_WB_PORTS-1:0]              we_q, we_d;
  logic [NUM_WB_PORTS-1:0][PREG_W-1:0]  pd_q, pd_d;
  logic [NUM_WB_PORTS-1:0][DATA_W-1:0]  data_q, data_d;
  logic [NUM_WB_PORTS-1:0][ROB_W-1:0]   rob_q, rob_d;

  logic [NUM_REQ-1:0]                   gnt0, gnt1;
  logic                                 found0, found1;
  logic [PTR_W-1:0]                     idx0, idx1;
  logic [NUM_WB_PORTS-1:0]              found;
  logic [NUM_WB_PORTS-1:0][PTR_W-1:0]   idx;
  logic                                 grant_en;

  wb_port_arbiter_rr_pick2 #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid_i  (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .found0_o (found0),
    .found1_o (found1),
    .idx0_o   (idx0),
    .idx1_o   (idx1)
  );

  // rst is active-low: grants only while out of reset and not flushing.
  assign grant_en  = rst && !flush;
  assign req_ready = grant_en ? (gnt0 | gnt1) : '0;
  assign found     = {found1, found0};
  assign idx       = {idx1, idx0};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_en && found1) begin
      rr_ptr_d = PTR_W'(wb_next_idx(int'(idx1), NUM_REQ));
    end else if (grant_en && found0) begin
      rr_ptr_d = PTR_W'(wb_next_idx(int'(idx0), NUM_REQ));
    end
  end

  // Unused ports keep their tag/data; only the valid and write enable drop.
  always_comb begin
    valid_d = '0;
    we_d    = '0;
    pd_d    = pd_q;
    data_d  = data_q;
    rob_d   = rob_q;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (grant_en && found[p]) begin
        valid_d[p] = 1'b1;
        we_d[p]    = (req_pd[idx[p]] != '0);
        pd_d[p]    = req_pd[idx[p]];
        data_d[p]  = req_data[idx[p]];
        rob_d[p]   = req_rob[idx[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      valid_q  <= '0;
      we_q     <= '0;
      pd_q     <= '0;
      data_q   <= '0;
      rob_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      pd_q     <= pd_d;
      data_q   <= data_d;
      rob_q    <= rob_d;
    end
  end

  assign regf_we   = we_q;
  assign rd_s      = pd_q;
  assign rd_v      = data_q;
  assign cdb_valid = valid_q;
  assign cdb_pd    = pd_q;
  assign cdb_rob   = rob_q;

  // Renaming guarantees distinct non-zero destinations within one cycle.
  same_pd_both_ports: assert property (@(posedge clk)
    (grant_en && found0 && found1 && req_pd[idx0] != '0) |-> (req_pd[idx0] != req_pd[idx1]));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a rotating-priority reference model.
module tb_wb_port_arbiter;

  localparam int N  = 4;
  localparam int PW = 7;
  localparam int DW = 32;
  localparam int RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, flush;
  logic [N-1:0]        req_valid, req_ready;
  logic [N-1:0][PW-1:0] req_pd;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0][RW-1:0] req_rob;
  logic [1:0]          regf_we, cdb_valid;
  logic [1:0][PW-1:0]  rd_s, cdb_pd;
  logic [1:0][DW-1:0]  rd_v;
  logic [1:0][RW-1:0]  cdb_rob;

  wb_port_arbiter #(.NUM_REQ(N), .PREG_W(PW), .DATA_W(DW), .ROB_W(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pd    (req_pd),
    .req_data  (req_data),
    .req_rob   (req_rob),
    .regf_we   (regf_we),
    .rd_s      (rd_s),
    .rd_v      (rd_v),
    .cdb_valid (cdb_valid),
    .cdb_pd    (cdb_pd),
    .cdb_rob   (cdb_rob)
  );

  int compared   = 0;
  int mismatched = 0;
  int rrModel    = 0;

  logic [PW-1:0] pdArr[N];
  logic [DW-1:0] dataArr[N];
  logic [RW-1:0] robArr[N];
  logic [N-1:0]  pending;
  logic [N-1:0]  acc;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic flushV, input logic [N-1:0] validV);
    rst       = rstV;
    flush     = flushV;
    req_valid = validV;
    for (int i = 0; i < N; i++) begin
      req_pd[i]   = pdArr[i];
      req_data[i] = dataArr[i];
      req_rob[i]  = robArr[i];
    end
  endtask

  task automatic checkPort(input int p, input int g);
    logic expWe;
    expWe = (g >= 0) ? (pdArr[g] != '0) : 1'b0;
    checkVal($sformatf("cdb_valid[%0d]", p), 64'(cdb_valid[p]), 64'(g >= 0));
    checkVal($sformatf("regf_we[%0d]", p), 64'(regf_we[p]), 64'(expWe));
    if (g >= 0) begin
      checkVal($sformatf("rd_s[%0d]", p), 64'(rd_s[p]), 64'(pdArr[g]));
      checkVal($sformatf("cdb_pd[%0d]", p), 64'(cdb_pd[p]), 64'(pdArr[g]));
      checkVal($sformatf("rd_v[%0d]", p), 64'(rd_v[p]), 64'(dataArr[g]));
      checkVal($sformatf("cdb_rob[%0d]", p), 64'(cdb_rob[p]), 64'(robArr[g]));
    end
  endtask

  // Model: scan upward from the pointer, first two valid requesters win.
  task automatic checkOutput(output logic [N-1:0] accepted);
    int g0, g1, i;
    logic [N-1:0] expReady;
    g0 = -1;
    g1 = -1;
    if (rst && !flush) begin
      for (int k = 0; k < N; k++) begin
        i = (rrModel + k) % N;
        if (req_valid[i]) begin
          if (g0 < 0) g0 = i;
          else if (g1 < 0) g1 = i;
        end
      end
    end
    expReady = '0;
    if (g0 >= 0) expReady[g0] = 1'b1;
    if (g1 >= 0) expReady[g1] = 1'b1;
    accepted = expReady;

    @(negedge clk);
    checkVal("req_ready", 64'(req_ready), 64'(expReady));
    @(posedge clk);
    #1;
    if (!rst) begin
      rrModel = 0;
      checkVal("rst.regf_we", 64'(regf_we), 64'(0));
      checkVal("rst.cdb_valid", 64'(cdb_valid), 64'(0));
      checkVal("rst.rd_s", 64'(rd_s), 64'(0));
      checkVal("rst.rd_v", 64'(rd_v), 64'(0));
      checkVal("rst.cdb_pd", 64'(cdb_pd), 64'(0));
      checkVal("rst.cdb_rob", 64'(cdb_rob), 64'(0));
    end else begin
      if (g1 >= 0) rrModel = (g1 + 1) % N;
      else if (g0 >= 0) rrModel = (g0 + 1) % N;
      checkPort(0, g0);
      checkPort(1, g1);
    end
    checkVal("rr_ptr", 64'(dut.rr_ptr_q), 64'(rrModel));
  endtask

  initial begin
    bit rstV, flushV;
    $display("[TB] start");
    pending = '0;
    for (int i = 0; i < N; i++) begin
      pdArr[i]   = PW'(10 + i);
      dataArr[i] = 32'hA000_0000 + 32'(i);
      robArr[i]  = RW'(i);
    end

    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 4'b1111);
      checkOutput(acc);
    end

    pdArr[2]   = 7'd9;
    dataArr[2] = 32'hDEAD_BEEF;
    robArr[2]  = 5'd3;
    applyStimulus(1'b1, 1'b0, 4'b0100);
    checkOutput(acc);
    checkVal("single.regf_we", 64'(regf_we), 64'(2'b01));
    checkVal("single.rd_v0", 64'(rd_v[0]), 64'(32'hDEAD_BEEF));

    applyStimulus(1'b0, 1'b0, 4'b0000);
    checkOutput(acc);
    pdArr[2] = 7'd12;
    repeat (4) begin
      applyStimulus(1'b1, 1'b0, 4'b1111);
      checkOutput(acc);
    end

    pdArr[1] = 7'd0;
    applyStimulus(1'b1, 1'b0, 4'b0010);
    checkOutput(acc);
    checkVal("p0.cdb_valid", 64'(cdb_valid), 64'(2'b01));
    checkVal("p0.regf_we", 64'(regf_we), 64'(2'b00));
    pdArr[1] = 7'd11;

    applyStimulus(1'b1, 1'b1, 4'b1001);
    checkOutput(acc);

    applyStimulus(1'b1, 1'b0, 4'b0100);
    checkOutput(acc);
    applyStimulus(1'b1, 1'b0, 4'b1101);
    checkOutput(acc);
    checkVal("bp.port0_rob", 64'(cdb_rob[0]), 64'(robArr[3]));
    applyStimulus(1'b1, 1'b0, 4'b0100);
    checkOutput(acc);

    for (int c = 0; c < 400; c++) begin
      rstV   = ($urandom_range(0, 39) != 0);
      flushV = ($urandom_range(0, 14) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 2) != 0) begin
          pending[i] = 1'b1;
          pdArr[i]   = {5'($urandom), 2'(i)};
          dataArr[i] = $urandom;
          robArr[i]  = 5'($urandom);
        end
      end
      applyStimulus(rstV, flushV, pending);
      checkOutput(acc);
      if (!rstV || flushV) pending = '0;
      else pending = pending & ~acc;
    end

    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput(acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
